rx_frame_sr: RTL
================

Name: rx_frame_sr

Overview:
Parametrised serial-to-parallel frame capture block for the UART receive path. It shifts in one serial bit per shift_strobe and counts frame bits itself. When a frame is complete it presents the data word, checks parity and stop bits, and pulses packet_valid for one cycle. It generalises the fixed 9-bit data+stop shifter: data width, parity, stop-bit count and bit order are configurable, and it adds frame counting, error flags and abort.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..16
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits per frame, 1 or 2
MSB_FIRST, 0, 0 = first data bit received is packet_data[0]; 1 = first data bit is packet_data[DATA_BITS-1]

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
shift_strobe  in  1  one-cycle pulse: sample serial_in this cycle
serial_in  in  1  serial line bit (start bit already stripped upstream)
clear  in  1  abort the current frame; the counter returns to 0
packet_data  out  DATA_BITS  data word of the last completed frame
stop_ok  out  1  all stop bits of the last frame were 1
parity_err  out  1  parity mismatch on the last frame; 0 if PARITY_EN=0
framing_err  out  1  equals !stop_ok, provided as a separate flag
packet_valid  out  1  one-cycle pulse when a frame completes
bit_count  out  clog2(FRAME_BITS+1)  frame bits captured so far in the current frame

Behaviour:
- FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS. Frame order: data bits, then parity (if enabled), then stop bit(s).
- Internal shift register: FRAME_BITS wide. Each cycle with shift_strobe=1 and clear=0, it shifts serial_in in and bit_count increments.
- Completion: the strobe that brings bit_count from FRAME_BITS-1 to FRAME_BITS is the final strobe. On the next rising edge:
  - packet_data, stop_ok, parity_err and framing_err load from the full frame (including the final bit).
  - packet_valid=1 for exactly one cycle.
  - bit_count returns to 0.
  - bit_count never holds FRAME_BITS for a visible cycle.
- Latency: packet_valid goes high on the clock edge that samples the final strobe.
- Parity check:
  - p = XOR of the data bits XOR the parity bit.
  - Even mode: parity_err = p.
  - Odd mode: parity_err = !p.
- stop_ok = AND of all stop bits.
- Hold: packet_data and the flags hold their values until the next completion, and are not disturbed by partial frames, clear or strobes.
- clear=1: bit_count goes to 0 and the partial shift contents are discarded. A shift_strobe in the same cycle is ignored. Outputs are not affected, and no packet_valid is generated.
- Back-to-back: strobes on consecutive cycles are legal. A strobe in the cycle packet_valid is high is counted as bit 1 of the next frame.
- serial_in is ignored when shift_strobe=0.
- Reset (rst=1) dominates clear and shift_strobe. Outputs after reset:
  - bit_count=0, packet_valid=0
  - packet_data=0
  - stop_ok=1, framing_err=0, parity_err=0
  - shift register all 1s (idle line)
- Reset mid-frame: partial data is discarded. The first strobe after rst deasserts is bit 1 of a new frame.
- Purely synchronous design, no latches; count and shift in a single always_ff, combinational next-state in an always_comb.

Test Plan:
1. Defaults; strobe bits 1,0,1,0,0,1,0,1 then stop=1, one strobe every 4 cycles -> packet_data=0xA5, stop_ok=1, framing_err=0, parity_err=0, packet_valid pulse 1 cycle, bit_count 0..8 then 0.
2. Defaults, same data with stop=0 -> packet_data=0xA5, framing_err=1, stop_ok=0; next good frame 0x3C clears framing_err.
3. PARITY_EN=1, PARITY_ODD=1, data 0x07 LSB-first, parity bit 0, stop 1 -> parity_err=0. Repeat with parity bit 1 -> parity_err=1.
4. DATA_BITS=8, after 4 strobes assert clear with a coincident strobe, then send frame 0x5A -> no valid during abort, bit_count=0 after clear, final packet_data=0x5A.
5. rst mid-frame after 5 bits, then frame 0xFF with strobes on every cycle, back-to-back with a second frame 0x01 -> first valid shows 0xFF, second valid exactly 9 cycles later shows 0x01. Outputs equal reset values while rst=1.
6. DATA_BITS=7, MSB_FIRST=1, STOP_BITS=2, bits 1,0,0,0,0,0,1 then stops 1,0 -> packet_data=7'h41, framing_err=1.

Source files
------------

// File: rtl/rx_frame_sr_if.sv
// rtl/rx_frame_sr_if.sv - signal bundle between a serial bit source and rx_frame_sr
// Ports (master = bit source, slave = rx_frame_sr):
//   shift_strobe, serial_in, clear                 master -> slave
//   packet_data, stop_ok, parity_err, framing_err,
//   packet_valid, bit_count                         slave -> master
interface rx_frame_sr_if #(
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
);
  localparam int FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic                 shift_strobe;
  logic                 serial_in;
  logic                 clear;
  logic [DATA_BITS-1:0] packet_data;
  logic                 stop_ok;
  logic                 parity_err;
  logic                 framing_err;
  logic                 packet_valid;
  logic [CNT_W-1:0]     bit_count;

  modport master (
    output shift_strobe, serial_in, clear,
    input  packet_data, stop_ok, parity_err, framing_err, packet_valid, bit_count
  );

  modport slave (
    input  shift_strobe, serial_in, clear,
    output packet_data, stop_ok, parity_err, framing_err, packet_valid, bit_count
  );
endinterface

// File: rtl/rx_frame_sr.sv
// rtl/rx_frame_sr.sv - serial-to-parallel UART frame capture with parity/stop checking
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - rx_frame_sr_if.slave: strobe/serial/clear in; captured word, flags,
//          one-cycle packet_valid and running bit_count out
module rx_frame_sr #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic           clk,
  input  logic           rst,
  rx_frame_sr_if.slave   bus
);
  localparam int FRAME_BITS = DATA_BITS + PARITY_EN + STOP_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] frame_w;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  stop_ok_q, stop_ok_d;
  logic                  parity_err_q, parity_err_d;
  logic                  valid_q;
  logic                  done_w;
  logic [DATA_BITS-1:0]  cap_data_w;
  logic                  cap_stop_w;
  logic                  cap_par_w;

  // New bits enter at the top and walk down, so once a frame is complete the
  // first bit received sits at bit 0. frame_w is the register contents with the
  // current serial_in already shifted in, which lets the final strobe's bit be
  // captured on the same edge.
  assign frame_w = FRAME_BITS'({bus.serial_in, shreg_q} >> 1);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_w  = 1'b0;
    if (bus.clear) begin
      shreg_d = '1;
      cnt_d   = '0;
    end else if (bus.shift_strobe) begin
      shreg_d = frame_w;
      if (cnt_q == LAST_CNT) begin
        done_w = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    cap_data_w = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      cap_data_w[i] = (MSB_FIRST != 0) ? frame_w[DATA_BITS-1-i] : frame_w[i];
    end
    cap_stop_w = &frame_w[FRAME_BITS-1 -: STOP_BITS];
    // frame_w[DATA_BITS] is the parity bit when parity is enabled.
    cap_par_w  = (PARITY_EN != 0) ? ((^frame_w[DATA_BITS:0]) ^ (PARITY_ODD != 0)) : 1'b0;

    data_d       = done_w ? cap_data_w : data_q;
    stop_ok_d    = done_w ? cap_stop_w : stop_ok_q;
    parity_err_d = done_w ? cap_par_w  : parity_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q      <= '1;
      cnt_q        <= '0;
      data_q       <= '0;
      stop_ok_q    <= 1'b1;
      parity_err_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      stop_ok_q    <= stop_ok_d;
      parity_err_q <= parity_err_d;
      valid_q      <= done_w;
    end
  end

  assign bus.packet_data  = data_q;
  assign bus.stop_ok      = stop_ok_q;
  assign bus.framing_err  = ~stop_ok_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.packet_valid = valid_q;
  assign bus.bit_count    = cnt_q;
endmodule
